vga_fb_reader: RTL and testbench

//  Scan-out side of the framebuffer: the reader counterpart of the pixel writer (addr_x/addr_y/color/we, wr_gnt).

---
 rtl/vga_fb_reader.sv | 154 +++++++++++++++
 tb/tb_vga_fb_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
// Framebuffer scan-out reader: raster-order read requests with credit-based flow control,
// in-order return FIFO, and pixel hand-off tagged with start-of-frame / end-of-line.
module vga_fb_reader #(
  parameter int H_W        = 11,
  parameter int V_W        = 11,
  parameter int COLOR_W    = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [H_W-1:0]     res_x_i,
  input  logic [V_W-1:0]     res_y_i,
  output logic               rd_req_o,
  output logic [H_W-1:0]     rd_x_o,
  output logic [V_W-1:0]     rd_y_o,
  input  logic               rd_gnt_i,
  input  logic               rd_valid_i,
  input  logic [COLOR_W-1:0] rd_color_i,
  output logic               pix_valid_o,
  input  logic               pix_ready_i,
  output logic [COLOR_W-1:0] pix_color_o,
  output logic               pix_sof_o,
  output logic               pix_eol_o,
  output logic               underrun_o,
  output logic               busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_CRD = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [H_W-1:0]     x, lim_x;
  logic [V_W-1:0]     y, lim_y;
  logic [CW-1:0]      inflight, count;
  logic [AW-1:0]      wp, rp, sq_wp, sq_rp;
  logic [COLOR_W+1:0] fifo_mem [FIFO_DEPTH];
  logic [1:0]         side_mem [FIFO_DEPTH];
  logic               pushed_seen, underrun;
  logic [CW:0]        credit;
  logic               grant, rsp, push, pop, head_valid;
  logic               last_x, last_y, frame_end, sof_req, start;

  // A resolution of 0 is treated as 1, so the limit saturates at 0.
  function automatic logic [H_W-1:0] lim_of_x(input logic [H_W-1:0] r);
    return (r == '0) ? '0 : r - H_W'(1);
  endfunction

  function automatic logic [V_W-1:0] lim_of_y(input logic [V_W-1:0] r);
    return (r == '0) ? '0 : r - V_W'(1);
  endfunction

  assign credit     = {1'b0, inflight} + {1'b0, count};
  assign rd_req_o   = (state == RUN) && (credit < DEPTH_CRD);
  assign grant      = rd_req_o && rd_gnt_i;
  assign rsp        = rd_valid_i && (inflight != '0);
  assign push       = rsp;
  assign head_valid = (count != '0);
  assign pop        = head_valid && pix_ready_i;
  assign last_x     = (x == lim_x);
  assign last_y     = (y == lim_y);
  assign frame_end  = grant && last_x && last_y;
  assign sof_req    = (x == '0) && (y == '0);
  assign start      = (state == IDLE) && en_i;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en_i) state_nxt = RUN;
      RUN:     if (frame_end && !en_i) state_nxt = DRAIN;
      DRAIN:   if ((inflight == '0) && (count == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      lim_x       <= '0;
      lim_y       <= '0;
      inflight    <= '0;
      count       <= '0;
      wp          <= '0;
      rp          <= '0;
      sq_wp       <= '0;
      sq_rp       <= '0;
      pushed_seen <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        x     <= '0;
        y     <= '0;
        lim_x <= lim_of_x(res_x_i);
        lim_y <= lim_of_y(res_y_i);
      end else if (grant) begin
        if (last_x) begin
          x <= '0;
          if (last_y) begin
            // Frame wrap: pick up the resolution for the next frame.
            y     <= '0;
            lim_x <= lim_of_x(res_x_i);
            lim_y <= lim_of_y(res_y_i);
          end else begin
            y <= y + V_W'(1);
          end
        end else begin
          x <= x + H_W'(1);
        end
      end
      unique case ({grant, rsp})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push)  wp    <= wp + AW'(1);
      if (pop)   rp    <= rp + AW'(1);
      if (grant) sq_wp <= sq_wp + AW'(1);
      if (rsp)   sq_rp <= sq_rp + AW'(1);
      if (start) pushed_seen <= 1'b0;
      else if (push) pushed_seen <= 1'b1;
      if ((state == RUN) && pix_ready_i && !head_valid && pushed_seen) underrun <= 1'b1;
    end
  end

  // Storage: side queue carries the sof/eol tags of requests still in flight.
  always_ff @(posedge clk_i) begin
    if (grant) side_mem[sq_wp] <= {sof_req, last_x};
    if (push)  fifo_mem[wp]    <= {rd_color_i, side_mem[sq_rp]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(push && !pop && (count == DEPTH_CNT)));
  end

  assign pix_valid_o = head_valid;
  assign {pix_color_o, pix_sof_o, pix_eol_o} = head_valid ? fifo_mem[rp] : '0;
  assign rd_x_o      = x;
  assign rd_y_o      = y;
  assign underrun_o  = underrun;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: memory responder model with programmable latency/grant pattern,
// scoreboard of expected pixels pushed at grant and popped by an independent pixel monitor.
module tb_vga_fb_reader;
  localparam int H_W = 11, V_W = 11, COLOR_W = 2, FIFO_DEPTH = 16;

  logic               clk = 1'b0;
  logic               rst_i, en_i, rd_req_o, rd_gnt_i, rd_valid_i;
  logic [H_W-1:0]     res_x_i, rd_x_o;
  logic [V_W-1:0]     res_y_i, rd_y_o;
  logic [COLOR_W-1:0] rd_color_i, pix_color_o;
  logic               pix_valid_o, pix_ready_i, pix_sof_o, pix_eol_o, underrun_o, busy_o;

  always #5 clk = ~clk;

  vga_fb_reader #(.H_W(H_W), .V_W(V_W), .COLOR_W(COLOR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .res_x_i(res_x_i), .res_y_i(res_y_i),
    .rd_req_o(rd_req_o), .rd_x_o(rd_x_o), .rd_y_o(rd_y_o), .rd_gnt_i(rd_gnt_i),
    .rd_valid_i(rd_valid_i), .rd_color_i(rd_color_i), .pix_valid_o(pix_valid_o),
    .pix_ready_i(pix_ready_i), .pix_color_o(pix_color_o), .pix_sof_o(pix_sof_o),
    .pix_eol_o(pix_eol_o), .underrun_o(underrun_o), .busy_o(busy_o)
  );

  typedef struct packed {logic [1:0] c; logic sof; logic eol;} pix_t;
  typedef struct packed {logic [31:0] due; logic [1:0] c;} resp_t;

  pix_t           sb[$];
  resp_t          pend[$];
  logic [21:0]    gq[$];
  logic [1:0]     plog[$];
  int             n_cmp = 0, n_bad = 0;
  int             lat = 1, ngrant = 0;
  logic [31:0]    cyc = 0;
  bit             gnt_tog = 0, tog = 0, held = 0;
  logic [H_W-1:0] mx, mlx, hx;
  logic [V_W-1:0] my, mly, hy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [H_W-1:0] limx(input logic [H_W-1:0] r);
    return (r == 0) ? '0 : r - H_W'(1);
  endfunction
  function automatic logic [V_W-1:0] limy(input logic [V_W-1:0] r);
    return (r == 0) ? '0 : r - V_W'(1);
  endfunction
  function automatic logic [1:0] mcol(input int x, input int y);
    return 2'((x + 3 * y) & 3);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step(2);
    rst_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    for (int i = 0; i < budget && busy_o; i++) @(negedge clk);
    @(negedge clk);
    chk(nm, {31'd0, busy_o}, 32'd0);
    chk({nm, "_sb_empty"}, sb.size(), 0);
    step(1);
  endtask

  // Memory side: grants, address order model, expected pixels, delayed in-order returns.
  initial begin
    bit   g;
    pix_t e;
    rd_gnt_i = 1'b0; rd_valid_i = 1'b0; rd_color_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_i) begin
        pend.delete(); sb.delete(); gq.delete(); plog.delete();
        held = 0; ngrant = 0; tog = 0;
        mx = '0; my = '0; mlx = limx(res_x_i); mly = limy(res_y_i);
        rd_gnt_i = 1'b0; rd_valid_i = 1'b0; rd_color_i = '0;
      end else begin
        if (held) begin
          chk("hold_req", {31'd0, rd_req_o}, 32'd1);
          chk("hold_addr", {rd_x_o, rd_y_o}, {hx, hy});
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          rd_valid_i = 1'b1; rd_color_i = pend[0].c; void'(pend.pop_front());
        end else begin
          rd_valid_i = 1'b0; rd_color_i = '0;
        end
        tog = ~tog;
        g = gnt_tog ? tog : 1'b1;
        rd_gnt_i = g;
        held = 0;
        if (rd_req_o && g) begin
          chk("req_addr", {rd_x_o, rd_y_o}, {mx, my});
          e = '{c: mcol(int'(mx), int'(my)), sof: (mx == 0 && my == 0), eol: (mx == mlx)};
          sb.push_back(e);
          pend.push_back('{due: cyc + 32'(lat), c: e.c});
          gq.push_back({mx, my});
          ngrant++;
          if (mx == mlx) begin
            mx = '0;
            if (my == mly) begin
              my = '0; mlx = limx(res_x_i); mly = limy(res_y_i);
            end else my = my + V_W'(1);
          end else mx = mx + H_W'(1);
        end else if (rd_req_o) begin
          held = 1; hx = rd_x_o; hy = rd_y_o;
        end
      end
    end
  end

  // Pixel monitor: pops the scoreboard on every accepted pixel.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && pix_valid_o && pix_ready_i) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pix_unexpected: actual=%0h required=none", {pix_color_o, pix_sof_o, pix_eol_o});
        end else begin
          e = sb.pop_front();
          chk("pix", {28'd0, pix_color_o, pix_sof_o, pix_eol_o}, {28'd0, e});
          plog.push_back({pix_sof_o, pix_eol_o});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ex[9];
    int ey[9];
    ex = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    ey = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    rst_i = 1'b1; en_i = 1'b0; pix_ready_i = 1'b0; res_x_i = 11'd4; res_y_i = 11'd2;
    step(3);
    @(negedge clk);
    chk("reset_state", {rd_req_o, pix_valid_o, busy_o, underrun_o, pix_sof_o, pix_eol_o,
                        pix_color_o, rd_x_o, rd_y_o}, 32'd0);
    step(1);

    // 4x2 raster, always granted, latency 1
    pix_ready_i = 1'b1; gnt_tog = 0; lat = 1;
    do_reset(); en_i = 1'b1;
    step(20);
    chk("t1_grants", {31'd0, gq.size() >= 9}, 32'd1);
    for (int i = 0; i < 9 && i < gq.size(); i++)
      chk("t1_addr", gq[i], {11'(ex[i]), 11'(ey[i])});
    chk("t1_pixels", {31'd0, plog.size() >= 8}, 32'd1);
    for (int i = 0; i < 8 && i < plog.size(); i++)
      chk("t1_flags", plog[i], {i == 0, (i == 3) || (i == 7)});
    en_i = 1'b0;
    wait_idle("t1_idle", 100);

    // toggling grant, latency 5, resolution change mid-session including a zero height
    gnt_tog = 1; lat = 5;
    do_reset(); en_i = 1'b1;
    step(30);
    res_x_i = 11'd3; res_y_i = 11'd0;
    step(40);
    en_i = 1'b0;
    wait_idle("t2_idle", 300);

    // consumer stalled: credits cap the number of grants
    res_x_i = 11'd8; res_y_i = 11'd4; gnt_tog = 0; lat = 1; pix_ready_i = 1'b0;
    do_reset(); en_i = 1'b1;
    step(40);
    chk("t3_grants", ngrant, FIFO_DEPTH);
    @(negedge clk);
    chk("t3_req_low", {31'd0, rd_req_o}, 32'd0);
    chk("t3_fifo_full", {31'd0, pix_valid_o}, 32'd1);
    step(1);
    pix_ready_i = 1'b1;
    step(20);
    en_i = 1'b0;
    wait_idle("t3_idle", 200);

    // enable dropped mid-frame: frame completes, then drains
    lat = 2;
    do_reset(); en_i = 1'b1;
    step(10);
    en_i = 1'b0;
    wait_idle("t4_idle", 200);
    chk("t4_grants", ngrant, 32);
    chk("t4_last_addr", gq.size() > 0 ? gq[gq.size()-1] : 22'h3fffff, {11'd7, 11'd3});
    step(20);
    chk("t4_no_more", ngrant, 32);
    chk("t4_req_busy", {30'd0, rd_req_o, busy_o}, 32'd0);

    // long latency with consumer always ready: sticky underrun
    res_x_i = 11'd4; res_y_i = 11'd2; lat = 30;
    do_reset(); en_i = 1'b1;
    step(10);
    chk("t5_no_underrun_early", {31'd0, underrun_o}, 32'd0);
    step(110);
    chk("t5_underrun", {31'd0, underrun_o}, 32'd1);
    en_i = 1'b0;
    wait_idle("t5_idle", 400);
    chk("t5_underrun_sticky", {31'd0, underrun_o}, 32'd1);
    do_reset();
    chk("t5_underrun_cleared", {31'd0, underrun_o}, 32'd0);

    // reset pulse mid-frame aborts, rerun restarts at origin
    res_x_i = 11'd8; res_y_i = 11'd4; lat = 3;
    do_reset(); en_i = 1'b1;
    step(12);
    rst_i = 1'b1;
    step(1);
    @(negedge clk);
    chk("t6_abort", {29'd0, rd_req_o, pix_valid_o, busy_o}, 32'd0);
    step(1);
    rst_i = 1'b0;
    step(15);
    chk("t6_rerun_origin", gq.size() > 0 ? gq[0] : 22'h3fffff, 32'd0);
    en_i = 1'b0;
    wait_idle("t6_idle", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
